// File: rtl/serial_crc_ccitt_checker.sv
// Serial CRC-CCITT frame checker (x^16+x^12+x^5+1, MSB-first): zero residue over payload+CRC means pass.
// Optional frame statistics counters are enabled with `define SERIAL_CRC_CHECKER_STATS_EN.
module serial_crc_ccitt_checker #(
  parameter logic [15:0] INIT_VALUE = 16'h0000,
  parameter int unsigned LEN_W      = 16,
  parameter int unsigned MIN_BITS   = 17
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             m,
  input  logic             sof,
  input  logic             eof,
`ifdef SERIAL_CRC_CHECKER_STATS_EN
  input  logic             clr_stats,
  output logic [15:0]      frames_total,
  output logic [15:0]      frames_bad,
`endif
  output logic [15:0]      crc_out,
  output logic [15:0]      rx_crc,
  output logic [LEN_W-1:0] bit_cnt,
  output logic             busy,
  output logic             done,
  output logic             crc_ok,
  output logic             crc_err,
  output logic             frame_err
);

  localparam int unsigned CRC_W = 16;
  localparam int unsigned STAT_W = 16;

  typedef enum logic {IDLE, RECV} state_t;

  state_t             state, state_n;
  logic [CRC_W-1:0]   crc_n, rx_n;
  logic [LEN_W-1:0]   cnt_n;
  logic               ovf, ovf_n;
  logic               done_n, ok_n, err_n, ferr_n;

  // One LFSR step: feedback into bits 0, 5 and 12.
  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c, input logic b);
    logic f;
    f           = c[CRC_W-1] ^ b;
    crc_step    = {c[CRC_W-2:0], f};
    crc_step[5]  = c[4] ^ f;
    crc_step[12] = c[11] ^ f;
  endfunction

  // Next-state and result computation.
  always_comb begin
    state_n = state;
    crc_n   = crc_out;
    rx_n    = rx_crc;
    cnt_n   = bit_cnt;
    ovf_n   = ovf;
    done_n  = 1'b0;
    ok_n    = crc_ok;
    err_n   = crc_err;
    ferr_n  = frame_err;
    if (enable) begin
      if (sof) begin
        // sof always starts a fresh frame; an open frame or sof&eof reports frame_err
        crc_n   = crc_step(INIT_VALUE, m);
        rx_n    = {{(CRC_W-1){1'b0}}, m};
        cnt_n   = LEN_W'(1);
        ovf_n   = 1'b0;
        state_n = eof ? IDLE : RECV;
        if ((state == RECV) || eof) begin
          done_n = 1'b1;
          ok_n   = 1'b0;
          err_n  = 1'b0;
          ferr_n = 1'b1;
        end
      end else if (state == RECV) begin
        crc_n = crc_step(crc_out, m);
        rx_n  = {rx_crc[CRC_W-2:0], m};
        if (bit_cnt == {LEN_W{1'b1}}) begin
          ovf_n = 1'b1;
        end else begin
          cnt_n = bit_cnt + LEN_W'(1);
        end
        if (eof) begin
          state_n = IDLE;
          done_n  = 1'b1;
          if (ovf_n || (cnt_n < LEN_W'(MIN_BITS))) begin
            ok_n   = 1'b0;
            err_n  = 1'b0;
            ferr_n = 1'b1;
          end else begin
            ok_n   = (crc_n == '0);
            err_n  = (crc_n != '0);
            ferr_n = 1'b0;
          end
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      crc_out   <= INIT_VALUE;
      rx_crc    <= '0;
      bit_cnt   <= '0;
      ovf       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      crc_ok    <= 1'b0;
      crc_err   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      crc_out   <= crc_n;
      rx_crc    <= rx_n;
      bit_cnt   <= cnt_n;
      ovf       <= ovf_n;
      busy      <= (state_n == RECV);
      done      <= done_n;
      crc_ok    <= ok_n;
      crc_err   <= err_n;
      frame_err <= ferr_n;
    end
  end

`ifdef SERIAL_CRC_CHECKER_STATS_EN
  // Saturating frame counters, updated in the same edge that raises done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frames_total <= '0;
      frames_bad   <= '0;
    end else if (clr_stats) begin
      frames_total <= '0;
      frames_bad   <= '0;
    end else if (done_n) begin
      if (frames_total != {STAT_W{1'b1}}) frames_total <= frames_total + STAT_W'(1);
      if (!ok_n && (frames_bad != {STAT_W{1'b1}})) frames_bad <= frames_bad + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_serial_crc_ccitt_checker.sv
// Directed bench for serial_crc_ccitt_checker: one instance with INIT 0000, one with INIT FFFF, shared stimulus.
module tb_serial_crc_ccitt_checker;

  logic        clk;
  logic        reset_n;
  logic        enable, m, sof, eof;
  logic [15:0] crc0, rx0, cnt0, crc1, rx1, cnt1;
  logic        busy0, done0, ok0, err0, ferr0;
  logic        busy1, done1, ok1, err1, ferr1;
`ifdef SERIAL_CRC_CHECKER_STATS_EN
  logic        clr_stats;
  logic [15:0] ft0, fb0, ft1, fb1;
`endif

  serial_crc_ccitt_checker #(.INIT_VALUE(16'h0000)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .m(m), .sof(sof), .eof(eof),
`ifdef SERIAL_CRC_CHECKER_STATS_EN
    .clr_stats(clr_stats), .frames_total(ft0), .frames_bad(fb0),
`endif
    .crc_out(crc0), .rx_crc(rx0), .bit_cnt(cnt0), .busy(busy0), .done(done0),
    .crc_ok(ok0), .crc_err(err0), .frame_err(ferr0)
  );

  serial_crc_ccitt_checker #(.INIT_VALUE(16'hFFFF)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .m(m), .sof(sof), .eof(eof),
`ifdef SERIAL_CRC_CHECKER_STATS_EN
    .clr_stats(clr_stats), .frames_total(ft1), .frames_bad(fb1),
`endif
    .crc_out(crc1), .rx_crc(rx1), .bit_cnt(cnt1), .busy(busy1), .done(done1),
    .crc_ok(ok1), .crc_err(err1), .frame_err(ferr1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt0 = 0;
  int done_cnt1 = 0;
  logic [2:0]  res0[$];
  logic [15:0] cnt_at0[$];
  logic [2:0]  res1[$];
  logic        bits[$];
  int          base;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Result recorder: flags are {crc_ok, crc_err, frame_err}.
  always @(negedge clk) begin
    if (done0 === 1'b1) begin
      done_cnt0++;
      res0.push_back({ok0, err0, ferr0});
      cnt_at0.push_back(cnt0);
    end
    if (done1 === 1'b1) begin
      done_cnt1++;
      res1.push_back({ok1, err1, ferr1});
    end
  end

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) bits.push_back(b[i]);
  endtask

  task automatic push_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) bits.push_back(w[i]);
  endtask

  // "123456789" followed by crc; flip >= 0 inverts that payload bit.
  task automatic load_msg(input logic [15:0] crc, input int flip);
    bits.delete();
    for (int k = 0; k < 9; k++) push_byte(8'h31 + 8'(k));
    if (flip >= 0) bits[flip] = ~bits[flip];
    push_word(crc);
  endtask

  task automatic send_bits(input bit with_eof, input int gap_pct);
    for (int i = 0; i < bits.size(); i++) begin
      while ((gap_pct > 0) && ($urandom_range(0, 99) < gap_pct)) begin
        @(negedge clk);
        enable = 1'b0;
        m      = 1'($urandom_range(0, 1));
        sof    = 1'($urandom_range(0, 1));
        eof    = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      enable = 1'b1;
      m      = bits[i];
      sof    = (i == 0);
      eof    = with_eof && (i == bits.size() - 1);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    enable = 1'b0;
    sof    = 1'b0;
    eof    = 1'b0;
    m      = 1'b0;
  endtask

  task automatic wait_cnt(input string tag, input int which, input int target);
    int got;
    got = 0;
    for (int c = 0; c < 400; c++) begin
      idle();
      #1;
      got = (which == 0) ? done_cnt0 : done_cnt1;
      if (got >= target) break;
    end
    check(tag, 32'(got), 32'(target));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    enable = 1'b0; m = 1'b0; sof = 1'b0; eof = 1'b0;
`ifdef SERIAL_CRC_CHECKER_STATS_EN
    clr_stats = 1'b0;
`endif
    repeat (2) @(negedge clk);
    #1;
    check("rst_crc0", crc0, 16'h0000);
    check("rst_crc1", crc1, 16'hFFFF);
    check("rst_rx", rx0, 16'h0000);
    check("rst_cnt", cnt0, 16'd0);
    check("rst_flags", {busy0, done0, ok0, err0, ferr0}, 5'b00000);
    @(negedge clk);
    reset_n = 1'b1;

    // Good frame, exact done latency and one-cycle pulse
    base = done_cnt0;
    load_msg(16'h31C3, -1);
    send_bits(1'b1, 0);
    idle();
    #1;
    check("good_done_lat", done0, 1'b1);
    check("good_busy", busy0, 1'b0);
    check("good_flags", {ok0, err0, ferr0}, 3'b100);
    check("good_crc", crc0, 16'h0000);
    check("good_rx", rx0, 16'h31C3);
    check("good_cnt", cnt0, 16'd88);
    check("good_init1_err", {ok1, err1, ferr1}, 3'b010);
    idle();
    #1;
    check("good_done_pulse", done0, 1'b0);
    check("good_ndone", 32'(done_cnt0), 32'(base + 1));

    // Corrupted payload bit 5
    base = done_cnt0;
    load_msg(16'h31C3, 5);
    send_bits(1'b1, 0);
    wait_cnt("bad_wait", 0, base + 1);
    check("bad_flags", {ok0, err0, ferr0}, 3'b010);
    check("bad_crc_nonzero", (crc0 != 16'h0000), 1'b1);
    check("bad_cnt", cnt0, 16'd88);

    // INIT FFFF instance with random enable gaps
    base = done_cnt1;
    load_msg(16'h29B1, -1);
    send_bits(1'b1, 30);
    wait_cnt("init1_wait", 1, base + 1);
    check("init1_flags", {ok1, err1, ferr1}, 3'b100);
    check("init1_cnt", cnt1, 16'd88);
    check("init1_rx", rx1, 16'h29B1);
    check("init1_crc", crc1, 16'h0000);

    // 10-bit frame is too short
    base = done_cnt0;
    bits.delete();
    begin
      logic [9:0] v;
      v = 10'b1100110011;
      for (int i = 9; i >= 0; i--) bits.push_back(v[i]);
    end
    send_bits(1'b1, 0);
    wait_cnt("short_wait", 0, base + 1);
    check("short_flags", {ok0, err0, ferr0}, 3'b001);
    check("short_cnt", cnt0, 16'd10);
    check("short_rx", rx0, 16'h0333);

    // sof&eof on one beat with m=1
    base = done_cnt0;
    bits.delete();
    bits.push_back(1'b1);
    send_bits(1'b1, 0);
    wait_cnt("single_wait", 0, base + 1);
    check("single_flags", {ok0, err0, ferr0}, 3'b001);
    check("single_crc0", crc0, 16'h1021);
    check("single_crc1", crc1, 16'hFFFE);
    check("single_cnt", cnt0, 16'd1);
    check("single_rx", rx0, 16'h0001);

    // Abort after 40 bits by a new sof, then the new frame completes
    base = done_cnt0;
    bits.delete();
    for (int k = 0; k < 5; k++) push_byte(8'h31 + 8'(k));
    send_bits(1'b0, 0);
    load_msg(16'h31C3, -1);
    send_bits(1'b1, 0);
    wait_cnt("abort_wait", 0, base + 2);
    check("abort_flags", res0[base], 3'b001);
    check("abort_newcnt", cnt_at0[base], 16'd1);
    check("abort_next_flags", res0[base + 1], 3'b100);
    check("abort_next_cnt", cnt_at0[base + 1], 16'd88);

    // Reset after 30 bits
    base = done_cnt0;
    load_msg(16'h31C3, -1);
    while (bits.size() > 30) void'(bits.pop_back());
    send_bits(1'b0, 0);
    @(negedge clk);
    enable = 1'b0; sof = 1'b0; eof = 1'b0;
    reset_n = 1'b0;
    #1;
    check("mrst_crc0", crc0, 16'h0000);
    check("mrst_crc1", crc1, 16'hFFFF);
    check("mrst_rx", rx0, 16'h0000);
    check("mrst_cnt", cnt0, 16'd0);
    check("mrst_flags", {busy0, done0, ok0, err0, ferr0}, 5'b00000);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) idle();
    #1;
    check("mrst_no_done", 32'(done_cnt0), 32'(base));
    load_msg(16'h31C3, -1);
    send_bits(1'b1, 0);
    wait_cnt("mrst_good_wait", 0, base + 1);
    check("mrst_good_flags", {ok0, err0, ferr0}, 3'b100);

    // Back-to-back good then corrupted frame, no idle beat between
`ifdef SERIAL_CRC_CHECKER_STATS_EN
    @(negedge clk);
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
`endif
    base = done_cnt0;
    load_msg(16'h31C3, -1);
    send_bits(1'b1, 0);
    load_msg(16'h31C3, 5);
    send_bits(1'b1, 0);
    wait_cnt("b2b_wait", 0, base + 2);
    check("b2b_first", res0[base], 3'b100);
    check("b2b_first_cnt", cnt_at0[base], 16'd88);
    check("b2b_second", res0[base + 1], 3'b010);
    repeat (3) idle();
    #1;
    check("b2b_count", 32'(done_cnt0), 32'(base + 2));
`ifdef SERIAL_CRC_CHECKER_STATS_EN
    check("stats_total", ft0, 16'd2);
    check("stats_bad", fb0, 16'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
